// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// The controller and its word counter both import this package.
package imem_pkg;

    localparam int unsigned IMEM_WORDS = 1024;
    localparam int          LEN_W      = 11;

    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    // A load length is usable only if it is non-zero and fits in the memory.
    function automatic logic len_legal(input len_t len, input int unsigned words);
        return (len != {LEN_W{1'b0}}) && (32'(len) <= words);
    endfunction

endpackage

// File: rtl/imem_load_counter.sv
// Word counter for a program load.
// It tracks the next word index and flags when that word is the last one.
module imem_load_counter
    import imem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [LEN_W-1:0] i_len,
    output logic [LEN_W-1:0] o_count,
    output logic             o_last
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    logic [LEN_W-1:0] r_count;

    // Next-word index: cleared at load start, advanced on each accepted word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {LEN_W{1'b0}};
        end else if (i_clr) begin
            r_count <= {LEN_W{1'b0}};
        end else if (i_en) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_last  = ((r_count + ONE) == i_len);

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: streams a program into external memory,
// then releases the core and serves zero-latency fetches from that memory.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = IMEM_WORDS,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [10:0]       load_len,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       fetch_data,
    output logic              fetch_valid,
    output logic              fetch_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              core_run,
    output logic              load_done,
    output logic              len_err
);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic             r_len_err;
    logic [LEN_W-1:0] w_count;
    logic             w_last;
    logic             w_len_ok;
    logic             w_can_start;
    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_accept;
    logic             w_misalign;
    logic             w_oob;

    assign w_len_ok    = len_legal(load_len, MEM_WORDS);
    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign w_start_ok  = w_can_start && load_start && w_len_ok;
    assign w_start_bad = w_can_start && load_start && !w_len_ok;
    assign w_accept    = (r_state == ST_LOAD) && ld_valid;
    assign w_misalign  = (fetch_addr[1:0] != 2'b00);
    assign w_oob       = ({2'b00, fetch_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));

    imem_load_counter u_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start_ok),
        .i_en    (w_accept),
        .i_len   (r_len),
        .o_count (w_count),
        .o_last  (w_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latched load length and the one-cycle illegal-length pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= {LEN_W{1'b0}};
            r_len_err <= 1'b0;
        end else begin
            r_len     <= w_start_ok ? load_len : r_len;
            r_len_err <= w_start_bad;
        end
    end

    // Next-state logic; load_start is deliberately ignored in LOAD and DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_next = ST_LOAD;
                else            w_next = ST_IDLE;
            end
            ST_LOAD: begin
                if (w_accept && w_last) w_next = ST_DONE;
                else                    w_next = ST_LOAD;
            end
            ST_DONE: w_next = ST_RUN;
            ST_RUN: begin
                if (w_start_ok) w_next = ST_LOAD;
                else            w_next = ST_RUN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Output decode: memory port and fetch path are combinational so fetches cost no cycle
    always_comb begin
        ld_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {ADDR_W{1'b0}};
        mem_wdata   = 32'h0000_0000;
        core_run    = 1'b0;
        load_done   = 1'b0;
        fetch_err   = 1'b0;
        fetch_valid = 1'b0;
        fetch_data  = 32'h0000_0000;
        case (r_state)
            ST_LOAD: begin
                ld_ready = 1'b1;
                mem_addr = ADDR_W'({w_count, 2'b00});
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = ld_data;
                end else begin
                    mem_we    = 1'b0;
                    mem_wdata = 32'h0000_0000;
                end
            end
            ST_DONE: load_done = 1'b1;
            ST_RUN: begin
                core_run    = 1'b1;
                mem_addr    = fetch_addr;
                fetch_err   = fetch_en && (w_misalign || w_oob);
                fetch_valid = fetch_en && !(w_misalign || w_oob);
                if (fetch_en && !(w_misalign || w_oob)) fetch_data = mem_rdata;
                else                                    fetch_data = 32'h0000_0000;
            end
            default: ld_ready = 1'b0;
        endcase
    end

    assign len_err = r_len_err;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_imem_load_ctrl;

    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [10:0] load_len = 11'd0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = 32'h0;
    logic        fetch_en = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        ld_ready, fetch_valid, fetch_err, mem_we, core_run, load_done, len_err;
    logic [31:0] fetch_data, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem    [0:WORDS-1];
    logic [31:0] golden [0:WORDS-1];

    // model state: mode 0 idle, 1 loading, 2 just finished, 3 running
    int   m_mode = 0;
    int   m_cnt = 0;
    int   m_len = 0;
    logic m_lenerr = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_writes = 0;
    logic chk_en = 1'b0;

    imem_load_ctrl dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .fetch_valid(fetch_valid), .fetch_err(fetch_err), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .core_run(core_run), .load_done(load_done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr[31:2] < 30'd1024) ? mem[mem_addr[11:2]] : 32'h0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // external memory behaves like a simple RAM written by the strobe
    always @(negedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            n_writes <= n_writes + 1;
        end
    end

    // behavioural model: what the controller has accepted so far
    always @(posedge clk) begin
        if (rst) begin
            m_mode   <= 0;
            m_cnt    <= 0;
            m_len    <= 0;
            m_lenerr <= 1'b0;
        end else begin
            m_lenerr <= (m_mode == 0 || m_mode == 3) && load_start
                        && !(int'(load_len) >= 1 && int'(load_len) <= WORDS);
            if (m_mode == 0 || m_mode == 3) begin
                if (load_start && int'(load_len) >= 1 && int'(load_len) <= WORDS) begin
                    m_mode <= 1;
                    m_len  <= int'(load_len);
                    m_cnt  <= 0;
                end
            end else if (m_mode == 1) begin
                if (ld_valid) begin
                    golden[m_cnt] <= ld_data;
                    m_cnt <= m_cnt + 1;
                    if (m_cnt + 1 == m_len) m_mode <= 2;
                end
            end else begin
                m_mode <= 3;
            end
        end
    end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_run, e_load, e_err, e_val;
            logic [31:0] e_addr, e_data;
            e_run  = (m_mode == 3);
            e_load = (m_mode == 1);
            e_err  = e_run && fetch_en && ((fetch_addr % 4) != 0 || (fetch_addr / 4) >= WORDS);
            e_val  = e_run && fetch_en && !e_err;
            e_addr = e_load ? 32'(m_cnt * 4) : (e_run ? fetch_addr : 32'h0);
            e_data = e_val ? golden[fetch_addr[11:2]] : 32'h0;
            cmp("ld_ready",    {31'h0, ld_ready},    {31'h0, e_load});
            cmp("mem_we",      {31'h0, mem_we},      {31'h0, e_load && ld_valid});
            cmp("mem_addr",    mem_addr,             e_addr);
            cmp("mem_wdata",   mem_wdata,            (e_load && ld_valid) ? ld_data : 32'h0);
            cmp("core_run",    {31'h0, core_run},    {31'h0, e_run});
            cmp("load_done",   {31'h0, load_done},   {31'h0, m_mode == 2});
            cmp("len_err",     {31'h0, len_err},     {31'h0, m_lenerr});
            cmp("fetch_err",   {31'h0, fetch_err},   {31'h0, e_err});
            cmp("fetch_valid", {31'h0, fetch_valid}, {31'h0, e_val});
            cmp("fetch_data",  fetch_data,           e_data);
        end
    end

    initial begin
        logic [31:0] prog [0:3];
        int          wait_cyc;
        int          w0;
        prog[0] = 32'h0000_0013; prog[1] = 32'h0010_0093;
        prog[2] = 32'h0020_0113; prog[3] = 32'h0030_8193;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]    = 32'h0;
            golden[i] = 32'h0;
        end

        // reset, then outputs must all be quiet
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        cmp("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        cmp("rst_core_run", {31'h0, core_run}, 32'h0);
        cmp("rst_mem_addr", mem_addr, 32'h0);

        // four-word program back-to-back
        load_start = 1'b1; load_len = 11'd4;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = prog[i];
            @(negedge clk);
            cmp("prog_we",   {31'h0, mem_we}, 32'h1);
            cmp("prog_addr", mem_addr, 32'(i * 4));
            tick();
        end
        ld_valid = 1'b0;
        @(negedge clk);
        cmp("prog_done",  {31'h0, load_done}, 32'h1);
        cmp("prog_ready", {31'h0, ld_ready}, 32'h0);
        tick();
        fetch_en = 1'b1; fetch_addr = 32'h8;
        @(negedge clk);
        cmp("run_core_run", {31'h0, core_run}, 32'h1);
        cmp("fetch8_data",  fetch_data, 32'h0020_0113);
        tick();
        fetch_addr = 32'h6;
        @(negedge clk);
        cmp("fetch6_err",  {31'h0, fetch_err}, 32'h1);
        cmp("fetch6_data", fetch_data, 32'h0);
        tick();
        fetch_addr = 32'h1000;
        @(negedge clk);
        cmp("fetch1000_err", {31'h0, fetch_err}, 32'h1);
        tick();
        fetch_en = 1'b0;

        // reload of two words from RUN
        load_start = 1'b1; load_len = 11'd2;
        tick();
        load_start = 1'b0;
        @(negedge clk);
        cmp("reload_core_run", {31'h0, core_run}, 32'h0);
        ld_valid = 1'b1; ld_data = 32'hAAAA_0001;
        tick();
        ld_data = 32'hAAAA_0002;
        @(negedge clk);
        cmp("reload_addr1", mem_addr, 32'h4);
        tick();
        ld_valid = 1'b0;
        wait_cyc = 0;
        while (!core_run && wait_cyc < 10) begin
            tick();
            wait_cyc++;
        end
        cmp("reload_run_timeout", {31'h0, core_run}, 32'h1);

        // illegal lengths from IDLE
        rst = 1'b1; tick(); rst = 1'b0;
        load_start = 1'b1; load_len = 11'd0;
        tick();
        load_len = 11'd1025;
        @(negedge clk);
        cmp("lenerr0", {31'h0, len_err}, 32'h1);
        tick();
        load_start = 1'b0;
        @(negedge clk);
        cmp("lenerr1025", {31'h0, len_err}, 32'h1);
        tick();
        @(negedge clk);
        cmp("lenerr_idle", {31'h0, ld_ready | len_err | mem_we}, 32'h0);

        // three words with ld_valid toggling
        w0 = n_writes;
        load_start = 1'b1; load_len = 11'd3;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ld_valid = (i % 2 == 0); ld_data = $urandom();
            tick();
        end
        ld_valid = 1'b0;
        tick(); tick();
        cmp("toggle_writes", 32'(n_writes - w0), 32'd3);

        // reset in the middle of a five-word load
        load_start = 1'b1; load_len = 11'd5;
        tick();
        load_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h1111_1111; tick();
        ld_data = 32'h2222_2222; tick();
        ld_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        cmp("abort_outputs", {26'h0, ld_ready, mem_we, core_run, load_done, len_err, fetch_valid}, 32'h0);
        load_start = 1'b1; load_len = 11'd1;
        tick();
        load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'h3333_3333;
        @(negedge clk);
        cmp("abort_reload_addr", mem_addr, 32'h0);
        tick();
        ld_valid = 1'b0;
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            load_start = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 5))
                0:       load_len = 11'd0;
                1:       load_len = 11'($urandom_range(1025, 2047));
                2:       load_len = 11'($urandom_range(1, 40));
                default: load_len = 11'($urandom_range(1, 6));
            endcase
            ld_valid = ($urandom_range(0, 9) < 7);
            ld_data  = $urandom();
            fetch_en = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       fetch_addr = 32'($urandom_range(0, 31)) * 32'd4;
                1:       fetch_addr = 32'($urandom_range(0, 2047)) * 32'd4;
                2:       fetch_addr = 32'($urandom_range(0, 4095)) | 32'h1;
                default: fetch_addr = $urandom();
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
